// File: rtl/clk_div_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_pkg
// Shared definitions for the clk_div_bank divider bank.
//   CNT_W_DEF   : default counter / threshold width per channel
//   RST_THR_DEF : default threshold loaded into every channel at reset
//   thr_t       : threshold type at the default width
//   thr_lsb()   : bit offset of channel ch's threshold inside the packed
//                 div_thr bus (channel i occupies div_thr[i*CNT_W +: CNT_W])
// -----------------------------------------------------------------------------
package clk_div_pkg;

  localparam int CNT_W_DEF   = 24;
  localparam int RST_THR_DEF = 10;

  typedef logic [CNT_W_DEF-1:0] thr_t;

  function automatic int thr_lsb(input int ch, input int cnt_w);
    return ch * cnt_w;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// -----------------------------------------------------------------------------
// clk_div_chan
// One divider channel: counts advances from 0 to thr_a, then wraps, toggling
// clk_out and pulsing tick for one clk cycle. A new threshold is staged in a
// shadow register and only becomes active at a wrap (or while the channel is
// held in restart), so clk_out never produces a runt pulse.
//
// Ports:
//   clk      : system clock, posedge
//   rst_n    : asynchronous active-low reset
//   adv_in   : advance qualifier (1, or previous channel's tick in cascade)
//   en       : channel run enable (level)
//   sync_rst : 1-cycle bank restart pulse, highest synchronous priority
//   thr_in   : threshold value for this channel
//   thr_load : 1-cycle pulse, captures thr_in into the shadow register
//   clk_out  : registered divided clock, 50% duty
//   tick     : registered 1-cycle pulse on every clk_out toggle
// -----------------------------------------------------------------------------
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int RST_THR = RST_THR_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv_in,
  input  logic             en,
  input  logic             sync_rst,
  input  logic [CNT_W-1:0] thr_in,
  input  logic             thr_load,
  output logic             clk_out,
  output logic             tick
);

  localparam logic [CNT_W-1:0] RST_THR_V = CNT_W'(RST_THR);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] thr_a;
  logic [CNT_W-1:0] thr_s;
  logic [CNT_W-1:0] thr_next;

  // A load arriving on the same edge that thr_a is refreshed bypasses the
  // shadow so it takes effect immediately.
  assign thr_next = thr_load ? thr_in : thr_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
      thr_a   <= RST_THR_V;
      thr_s   <= RST_THR_V;
    end else begin
      if (thr_load) begin
        thr_s <= thr_in;
      end

      if (sync_rst || !en) begin
        cnt     <= '0;
        clk_out <= 1'b0;
        tick    <= 1'b0;
        thr_a   <= thr_next;
      end else if (adv_in) begin
        if (cnt == thr_a) begin
          cnt     <= '0;
          clk_out <= ~clk_out;
          tick    <= 1'b1;
          thr_a   <= thr_next;
        end else begin
          // cnt never exceeds thr_a, so this increment cannot overflow.
          cnt  <= cnt + CNT_W'(1);
          tick <= 1'b0;
        end
      end else begin
        tick <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/clk_div_bank.sv
// -----------------------------------------------------------------------------
// clk_div_bank
// N-channel programmable clock-divider bank. Each channel produces a 50%-duty
// divided clock and a one-cycle tick in the clk domain. The top level only
// decides what advances each channel; the counting lives in clk_div_chan.
//
// Optional feature (macro CLK_DIV_BANK_CASCADE_EN):
//   defined   : cascade_sel[i] (i>=1) makes channel i advance on the
//               registered tick of channel i-1 (one cycle of lag per stage).
//   undefined : cascade_sel is ignored; every channel advances every cycle
//               while enabled, and no inter-channel logic exists.
//
// Ports:
//   clk         : system clock, posedge
//   rst_n       : asynchronous active-low reset
//   div_thr     : per-channel threshold, channel i = div_thr[i*CNT_W +: CNT_W]
//   thr_load    : per-channel 1-cycle threshold capture pulse
//   ch_en       : per-channel run enable (level)
//   sync_rst    : 1-cycle pulse restarting all channels in phase
//   cascade_sel : per-channel cascade select (bit 0 ignored)
//   clk_out     : registered divided clocks
//   tick        : registered 1-cycle pulse on each clk_out toggle
// -----------------------------------------------------------------------------
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int RST_THR = RST_THR_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH*CNT_W-1:0] div_thr,
  input  logic [N_CH-1:0]       thr_load,
  input  logic [N_CH-1:0]       ch_en,
  input  logic                  sync_rst,
  input  logic [N_CH-1:0]       cascade_sel,
  output logic [N_CH-1:0]       clk_out,
  output logic [N_CH-1:0]       tick
);

  logic [N_CH-1:0] adv;

`ifdef CLK_DIV_BANK_CASCADE_EN
  // Channel 0 has no upstream neighbour, so its select bit has no meaning.
  logic unused_cascade;
  assign unused_cascade = cascade_sel[0];
`else
  logic unused_cascade;
  assign unused_cascade = ^cascade_sel;
`endif

  genvar i;
  generate
    for (i = 0; i < N_CH; i++) begin : g_ch
`ifdef CLK_DIV_BANK_CASCADE_EN
      if (i == 0) begin : g_head
        assign adv[i] = 1'b1;
      end else begin : g_link
        assign adv[i] = cascade_sel[i] ? tick[i-1] : 1'b1;
      end
`else
      assign adv[i] = 1'b1;
`endif

      clk_div_chan #(
        .CNT_W   (CNT_W),
        .RST_THR (RST_THR)
      ) u_chan (
        .clk      (clk),
        .rst_n    (rst_n),
        .adv_in   (adv[i]),
        .en       (ch_en[i]),
        .sync_rst (sync_rst),
        .thr_in   (div_thr[thr_lsb(i, CNT_W) +: CNT_W]),
        .thr_load (thr_load[i]),
        .clk_out  (clk_out[i]),
        .tick     (tick[i])
      );
    end
  endgenerate

endmodule

// File: tb/tb_clk_div_bank.sv
// -----------------------------------------------------------------------------
// tb_clk_div_bank
// Bench for clk_div_bank. The reference model describes each channel by the
// number of advances n since it last restarted and its period p = thr+1:
// tick fires when n is a positive multiple of p, clk_out is the parity of n/p.
// -----------------------------------------------------------------------------
module tb_clk_div_bank;

  localparam int N_CH  = 4;
  localparam int CNT_W = 24;

  logic                  clk;
  logic                  rst_n;
  logic [N_CH*CNT_W-1:0] div_thr;
  logic [N_CH-1:0]       thr_load;
  logic [N_CH-1:0]       ch_en;
  logic                  sync_rst;
  logic [N_CH-1:0]       cascade_sel;
  logic [N_CH-1:0]       clk_out;
  logic [N_CH-1:0]       tick;

  int tests;
  int fails;

  logic [2*N_CH-1:0] exp_q[$];

  clk_div_bank #(
    .N_CH    (N_CH),
    .CNT_W   (CNT_W),
    .RST_THR (10)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .div_thr     (div_thr),
    .thr_load    (thr_load),
    .ch_en       (ch_en),
    .sync_rst    (sync_rst),
    .cascade_sel (cascade_sel),
    .clk_out     (clk_out),
    .tick        (tick)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- model ----------------
  function automatic logic m_tick(input int n, input int p);
    return (n > 0) && ((n % p) == 0);
  endfunction

  function automatic logic m_out(input int n, input int p);
    return ((n / p) % 2) == 1;
  endfunction

  // ---------------- drivers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_thr(input int ch, input int val);
    div_thr[ch*CNT_W +: CNT_W] = CNT_W'(val);
  endtask

  // Loads val into the masked channels while they are held disabled, so the
  // value becomes active at once.
  task automatic load_disabled(input logic [N_CH-1:0] mask, input int val);
    ch_en = ch_en & ~mask;
    for (int c = 0; c < N_CH; c++) if (mask[c]) set_thr(c, val);
    thr_load = mask;
    cyc();
    thr_load = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    div_thr = '0; thr_load = '0; ch_en = '0; sync_rst = 1'b0; cascade_sel = '0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      tests++;
      if (clk_out !== '0 || tick !== '0) begin
        fails++;
        $display("FAIL reset_outputs: clk_out=%b tick=%b required 0/0", clk_out, tick);
      end
    end
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_basic();
    int highs, ticks;
    highs = 0; ticks = 0;
    ch_en = 4'b0001;
    for (int j = 1; j <= 50; j++) begin
      cyc();
      if (j <= 44) begin highs += int'(clk_out[0]); ticks += int'(tick[0]); end
      tests++;
      if (tick[0] !== m_tick(j, 11) || clk_out[0] !== m_out(j, 11) || tick[3:1] !== '0) begin
        fails++;
        $display("FAIL basic_thr10 edge %0d: clk_out=%b tick=%b required ch0 %b/%b", j, clk_out, tick,
                 m_out(j, 11), m_tick(j, 11));
      end
    end
    tests++;
    if (highs != 22 || ticks != 4) begin
      fails++;
      $display("FAIL basic_duty: high=%0d ticks=%0d required 22/4", highs, ticks);
    end
  endtask

  task automatic test_thr_small();
    ch_en = '0;
    cyc();
    load_disabled(4'b0010, 0);
    load_disabled(4'b0100, 1);
    ch_en = 4'b0110;
    for (int j = 1; j <= 12; j++) begin
      cyc();
      tests++;
      if (tick[1] !== 1'b1 || clk_out[1] !== m_out(j, 1) ||
          tick[2] !== m_tick(j, 2) || clk_out[2] !== m_out(j, 2)) begin
        fails++;
        $display("FAIL thr_small edge %0d: clk_out=%b tick=%b required ch1 %b/1 ch2 %b/%b", j, clk_out,
                 tick, m_out(j, 1), m_out(j, 2), m_tick(j, 2));
      end
    end
  endtask

  task automatic test_midload();
    int tick_edges[$];
    int tog;
    logic e_tick;
    tick_edges = '{5, 7, 9, 11, 15, 19};
    tog = 0;
    ch_en = '0;
    cyc();
    load_disabled(4'b0001, 4);
    ch_en = 4'b0001;
    for (int j = 1; j <= 22; j++) begin
      cyc();
      e_tick = 1'b0;
      foreach (tick_edges[k]) if (tick_edges[k] == j) e_tick = 1'b1;
      if (e_tick) tog++;
      tests++;
      if (tick[0] !== e_tick || clk_out[0] !== tog[0]) begin
        fails++;
        $display("FAIL midload edge %0d: clk_out0=%b tick0=%b required %b/%b", j, clk_out[0], tick[0],
                 tog[0], e_tick);
      end
      thr_load = '0;
      if (j == 2)  begin set_thr(0, 1); thr_load = 4'b0001; end
      if (j == 10) begin set_thr(0, 3); thr_load = 4'b0001; end
    end
    thr_load = '0;
  endtask

  task automatic test_sync();
    ch_en = '0;
    cyc();
    load_disabled(4'b0011, 3);
    ch_en = 4'b0001;
    cyc(); cyc();
    ch_en = 4'b0011;
    cyc(); cyc(); cyc();
    sync_rst = 1'b1;
    cyc();
    sync_rst = 1'b0;
    tests++;
    if (clk_out[1:0] !== 2'b00 || tick[1:0] !== 2'b00) begin
      fails++;
      $display("FAIL sync_restart: clk_out=%b tick=%b required 00/00", clk_out[1:0], tick[1:0]);
    end
    for (int j = 1; j <= 20; j++) begin
      cyc();
      tests++;
      if (tick[0] !== m_tick(j, 4) || tick[1] !== m_tick(j, 4) ||
          clk_out[0] !== m_out(j, 4) || clk_out[1] !== m_out(j, 4)) begin
        fails++;
        $display("FAIL sync_aligned edge %0d: clk_out=%b tick=%b required %b/%b on ch0,ch1", j,
                 clk_out[1:0], tick[1:0], m_out(j, 4), m_tick(j, 4));
      end
    end
    ch_en = 4'b0001;
    cyc();
    tests++;
    if (clk_out[1] !== 1'b0 || tick[1] !== 1'b0 || clk_out[0] !== m_out(21, 4)) begin
      fails++;
      $display("FAIL disable_ch1: clk_out=%b tick=%b required ch1 0/0 ch0 out %b", clk_out, tick,
               m_out(21, 4));
    end
  endtask

  task automatic test_cascade();
    int tog1;
    logic e_tick1;
    tog1 = 0;
    ch_en = '0;
    cyc();
    ch_en = '0;
    set_thr(0, 10);
    set_thr(1, 1);
    thr_load = 4'b0011;
    cyc();
    thr_load = '0;
    cascade_sel = 4'b0010;
    ch_en = 4'b0011;
    for (int j = 1; j <= 70; j++) begin
      cyc();
`ifdef CLK_DIV_BANK_CASCADE_EN
      e_tick1 = (j >= 23) && (((j - 1) % 22) == 0);
`else
      e_tick1 = m_tick(j, 2);
`endif
      if (e_tick1) tog1++;
      tests++;
      if (tick[0] !== m_tick(j, 11) || clk_out[0] !== m_out(j, 11) ||
          tick[1] !== e_tick1 || clk_out[1] !== tog1[0]) begin
        fails++;
        $display("FAIL cascade edge %0d: clk_out=%b tick=%b required ch0 %b/%b ch1 %b/%b", j, clk_out,
                 tick, m_out(j, 11), m_tick(j, 11), tog1[0], e_tick1);
      end
    end
    cascade_sel = '0;
  endtask

  task automatic test_random();
    int n[N_CH];
    int p[N_CH];
    int v;
    logic [N_CH-1:0] e_tick, e_out;
    logic [2*N_CH-1:0] exp_v, got_v;
    ch_en = '0;
    cyc();
    for (int c = 0; c < N_CH; c++) begin
      v = $urandom_range(0, 5);
      set_thr(c, v);
      p[c] = v + 1;
      n[c] = 0;
    end
    thr_load = '1;
    cyc();
    thr_load = '0;
    for (int cy = 0; cy < 400; cy++) begin
      sync_rst = ($urandom_range(0, 39) == 0);
      thr_load = '0;
`ifdef CLK_DIV_BANK_CASCADE_EN
      cascade_sel = '0;
`else
      cascade_sel = N_CH'($urandom);
`endif
      for (int c = 0; c < N_CH; c++) begin
        if ($urandom_range(0, 11) == 0) ch_en[c] = ~ch_en[c];
        if (!ch_en[c] && $urandom_range(0, 2) == 0) begin
          v = $urandom_range(0, 5);
          set_thr(c, v);
          thr_load[c] = 1'b1;
          p[c] = v + 1;
        end
        if (sync_rst || !ch_en[c]) n[c] = 0;
        else n[c]++;
        e_tick[c] = ch_en[c] && !sync_rst && m_tick(n[c], p[c]);
        e_out[c]  = ch_en[c] && !sync_rst && m_out(n[c], p[c]);
      end
      exp_q.push_back({e_out, e_tick});
      cyc();
      got_v = {clk_out, tick};
      exp_v = exp_q.pop_front();
      tests++;
      if (got_v !== exp_v) begin
        fails++;
        $display("FAIL random cycle %0d: {clk_out,tick}=%b required %b", cy, got_v, exp_v);
      end
    end
    sync_rst = 1'b0;
    thr_load = '0;
    cascade_sel = '0;
  endtask

  task automatic test_async_reset();
    ch_en = '0;
    cyc();
    load_disabled(4'b0001, 5);
    ch_en = 4'b0001;
    for (int j = 1; j <= 8; j++) cyc();
    tests++;
    if (clk_out[0] !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset_high: clk_out0=%b required 1", clk_out[0]);
    end
    #3;
    rst_n = 1'b0;
    #1;
    tests++;
    if (clk_out !== '0 || tick !== '0) begin
      fails++;
      $display("FAIL async_reset: clk_out=%b tick=%b required 0/0 before any edge", clk_out, tick);
    end
    cyc();
    rst_n = 1'b1;
    for (int j = 1; j <= 30; j++) begin
      cyc();
      tests++;
      if (tick[0] !== m_tick(j, 11) || clk_out[0] !== m_out(j, 11)) begin
        fails++;
        $display("FAIL reset_thr10 edge %0d: clk_out0=%b tick0=%b required %b/%b", j, clk_out[0],
                 tick[0], m_out(j, 11), m_tick(j, 11));
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_basic();
    test_thr_small();
    test_midload();
    test_sync();
    test_cascade();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
